// File: rtl/shift_reg_univ_if.sv
// Bus bundle for the universal shift register.
// Carries the operation controls in and the register view out.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             i_en;
  logic [2:0]       i_mode;
  logic             i_sin_r;
  logic             i_sin_l;
  logic [WIDTH-1:0] i_pdin;
  logic [WIDTH-1:0] o_pdout;
  logic             o_sout_msb;
  logic             o_sout_lsb;
  logic [CW-1:0]    o_cnt;
  logic             o_full;

  modport master (
    output i_en,
    output i_mode,
    output i_sin_r,
    output i_sin_l,
    output i_pdin,
    input  o_pdout,
    input  o_sout_msb,
    input  o_sout_lsb,
    input  o_cnt,
    input  o_full
  );

  modport slave (
    input  i_en,
    input  i_mode,
    input  i_sin_r,
    input  i_sin_l,
    input  i_pdin,
    output o_pdout,
    output o_sout_msb,
    output o_sout_lsb,
    output o_cnt,
    output o_full
  );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift, rotate, load, clear,
// plus a saturating count of shifts since the last load/clear.
module shift_reg_univ #(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  shift_reg_univ_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_LOAD = 3'b101,
    M_CLR  = 3'b110,
    M_RSVD = 3'b111
  } mode_e;

  mode_e mode;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    cnt_inc;

  logic op_shl;
  logic op_shr;
  logic op_rol;
  logic op_ror;
  logic op_load;
  logic op_clr;

  assign mode = mode_e'(bus.i_mode);

  // Disabled cycles decode to no operation, i.e. hold.
  assign op_shl  = bus.i_en && (mode == M_SHL);
  assign op_shr  = bus.i_en && (mode == M_SHR);
  assign op_rol  = bus.i_en && (mode == M_ROL);
  assign op_ror  = bus.i_en && (mode == M_ROR);
  assign op_load = bus.i_en && (mode == M_LOAD);
  assign op_clr  = bus.i_en && (mode == M_CLR);

  assign cnt_inc = (cnt_q == CNT_MAX)
                 ? cnt_q
                 : cnt_q + CNT_ONE;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      op_shl: begin
        q_d   = {q_q[WIDTH-2:0], bus.i_sin_r};
        cnt_d = cnt_inc;
      end
      op_shr: begin
        q_d   = {bus.i_sin_l, q_q[WIDTH-1:1]};
        cnt_d = cnt_inc;
      end
      op_rol: begin
        q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        cnt_d = cnt_inc;
      end
      op_ror: begin
        q_d   = {q_q[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_inc;
      end
      op_load: begin
        q_d   = bus.i_pdin;
        cnt_d = '0;
      end
      op_clr: begin
        q_d   = '0;
        cnt_d = '0;
      end
      default: begin
        q_d   = q_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_pdout    = q_q;
  assign bus.o_sout_msb = q_q[WIDTH-1];
  assign bus.o_sout_lsb = q_q[0];
  assign bus.o_cnt      = cnt_q;
  assign bus.o_full     = (cnt_q == CNT_MAX);
endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the next generation of the single-bit D flip-flop stage in the counter/shift-register set. It holds a WIDTH-bit word and supports hold, shift left and right, rotate left and right, parallel load and clear. A saturating shift counter reports how many shift or rotate operations have occurred since the last load or clear. It serves as a SIPO, PISO or ring register for serial-link and LED-pattern blocks, all in a single clock domain.

## Interface
- WIDTH, 8, register width in bits; legal range WIDTH ≥ 2.
- CW (derived localparam, not overridable), $clog2(WIDTH+1), width of the shift counter.
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rstn  input  1  reset, synchronous, active-low; dominates every other input.
- i_en  input  1  operation enable; 0 means hold regardless of i_mode.
- i_mode  input  3  operation select; encoding under Operation.
- i_sin_r  input  1  serial input entering bit 0 on shift left.
- i_sin_l  input  1  serial input entering bit WIDTH-1 on shift right.
- i_pdin  input  WIDTH  parallel load data.
- o_pdout  output  WIDTH  register contents q.
- o_sout_msb  output  1  q[WIDTH-1]; serial out for shift left.
- o_sout_lsb  output  1  q[0]; serial out for shift right.
- o_cnt  output  CW  shift/rotate count since last load or clear; saturates at WIDTH.
- o_full  output  1  high when o_cnt == WIDTH.

## Operation
- Priority at each rising edge: reset, then i_en = 0 (hold), then i_mode.
- i_mode encoding (only when i_en = 1):
  - 000: hold.
  - 001: shift left. q ← {q[W-2:0], i_sin_r}. cnt increments.
  - 010: shift right. q ← {i_sin_l, q[W-1:1]}. cnt increments.
  - 011: rotate left. q ← {q[W-2:0], q[W-1]}. cnt increments.
  - 100: rotate right. q ← {q[0], q[W-1:1]}. cnt increments.
  - 101: parallel load. q ← i_pdin. cnt ← 0.
  - 110: clear. q ← 0. cnt ← 0.
  - 111: reserved; behaves as hold.
- Counter:
  - Increments by 1 on modes 001–100 only.
  - Saturates at WIDTH. At WIDTH, further shifts still move q but cnt stays at WIDTH; it never wraps to 0.
  - Hold, reserved and disabled cycles leave cnt unchanged.
- o_full = (cnt == WIDTH). It is decoded from the registered count, with no extra register.
- Serial inputs are ignored in every mode except their own shift mode.
- No internal state machine beyond q and cnt. Every mode is one cycle, and modes may change every cycle.

## Timing
- Reset: at any edge with i_rstn = 0:
  - q ← 0 and cnt ← 0, so o_pdout = 0, o_sout_msb = 0, o_sout_lsb = 0, o_cnt = 0, o_full = 0.
  - Applies from the first such edge.
  - Reset mid-shift aborts the shift with no partial update.
- Latency: inputs sampled at edge N appear on every output after edge N (one cycle). No combinational path from any input to any output.
- o_sout_msb and o_sout_lsb are taken directly from q, so they change on the same edge as o_pdout.
- Load and shift in consecutive cycles:
  - The shift operates on the freshly loaded value.
  - cnt reads 0 after the load and 1 after the shift.
- Full-width SIPO: WIDTH consecutive shift-left edges after a load place the first sampled i_sin_r bit at q[WIDTH-1] and set o_full.
- Full-width PISO: after a load, o_sout_msb presents bits WIDTH-1 down to 0 on successive cycles while shift left is applied.

## Test plan
All scenarios use WIDTH = 8 and a 100-unit clock period.
- Reset: i_rstn = 0 for 2 edges with mode = 101, i_pdin = 8'hFF, i_en = 1 → o_pdout = 8'h00, o_cnt = 0, o_full = 0 after each edge.
- Load then shift left: load 8'hA5, then one edge with mode 001 and i_sin_r = 0 → o_pdout = 8'h4A, o_sout_msb = 0, o_sout_lsb = 0, o_cnt = 1.
- Rotates: load 8'h81.
  - Rotate right → 8'hC0.
  - Then rotate left twice → 8'h81 then 8'h03.
  - o_cnt = 3.
- SIPO with saturation: clear, then 8 shift-left edges with i_sin_r = 1,0,1,1,0,0,1,0 → o_pdout = 8'hB2, o_cnt = 8, o_full = 1.
  - A 9th shift with i_sin_r = 1 → 8'h65, o_cnt still 8.
- Enable and clear: load 8'h3C, then i_en = 0 with mode 001 for 3 edges → o_pdout stays 8'h3C, o_cnt = 0.
  - Then i_en = 1, mode 110 → o_pdout = 8'h00, o_cnt = 0.
  - Mode 111 for 2 edges → no change.
- Reset mid-operation: load 8'hF0, shift right 4 times with i_sin_l = 1 → 8'hFF, o_cnt = 4.
  - Then i_rstn = 0 for one edge with mode 001 held → o_pdout = 8'h00, o_cnt = 0.
  - Next shift left with i_sin_r = 1 → 8'h01, o_cnt = 1.
